// File: rtl/reg_file_sb.sv
// Integer register file with NREAD combinational read ports, one write port, hardwired-zero x0,
// optional write-to-read bypass and a per-register busy scoreboard (set on issue, cleared on write-back).
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AW-1:0]     ra,
  output logic [NREAD*XLEN-1:0]   rd,
  output logic [NREAD-1:0]        rs_busy,
  input  logic                    we,
  input  logic [AW-1:0]           wa,
  input  logic [XLEN-1:0]         wd,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  output logic [NREGS-1:0]        busy_vec
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  // One-hot issue/retire masks; bit 0 is masked so x0 can never become busy.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_valid) w_set[iss_rd] = 1'b1;
    if (we)        w_clr[wa]     = 1'b1;
    w_set[0] = 1'b0;
    w_clr[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (we && (wa != '0)) r_regs[wa] <= wd;
      // A new producer issued in the same cycle as a retiring one keeps the register busy.
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign busy_vec = r_busy;

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit;

    assign w_ra  = ra[p*AW +: AW];
    assign w_hit = (BYPASS != 0) && we && (wa == w_ra) && (wa != '0);

    assign rd[p*XLEN +: XLEN] = (!rst || (w_ra == '0)) ? '0 :
                                (w_hit ? wd : r_regs[w_ra]);
    // A write-back landing this cycle satisfies the dependency when it is forwarded.
    assign rs_busy[p] = rst && r_busy[w_ra] && !w_hit;
  end

endmodule
